// File: rtl/psw_debounce_pkg.sv
// Shared types and defaults for the push-switch debouncer.
// Enable the long-press detector by defining PSW_LONG_EN.
package psw_debounce_pkg;

  localparam int unsigned CNT_W = 25;

  localparam logic [CNT_W-1:0] DEB_CYCLES_DEF  = 25'd2000000;
  localparam logic [CNT_W-1:0] LONG_CYCLES_DEF = 25'd24000000;

  typedef enum logic [1:0] {
    S_REL    = 2'd0,
    S_DEB_DN = 2'd1,
    S_PRS    = 2'd2,
    S_DEB_UP = 2'd3
  } psw_state_e;

endpackage

// File: rtl/psw_debounce_sync.sv
// Two-flop synchronizer for the raw switch input; resets to the released level (1).
module psw_sync (
  input  logic CK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      meta <= 1'b1;
      Q    <= 1'b1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/psw_debounce.sv
// Push-switch debouncer with press/release pulses and optional long-press pulse.
// Long-press logic is compiled in only when PSW_LONG_EN is defined.
module psw_debounce
  import psw_debounce_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter logic [CNT_W-1:0] LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic CK,
  input  logic RST,
  input  logic PSW,
  output logic PSW_OUT,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG
);

  localparam logic [CNT_W-1:0] DEB_LAST = DEB_CYCLES - 1'b1;

  logic             sync;
  psw_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic             psw_out_d, press_d, release_d;

  psw_sync u_sync (
    .CK  (CK),
    .RST (RST),
    .D   (PSW),
    .Q   (sync)
  );

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_REL: begin
        if (!sync) begin
          state_d = S_DEB_DN;
          deb_d   = '0;
        end
      end
      S_DEB_DN: begin
        if (sync) begin
          state_d = S_REL;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = S_PRS;
          deb_d   = '0;
          press_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      S_PRS: begin
        if (sync) begin
          state_d = S_DEB_UP;
          deb_d   = '0;
        end
      end
      S_DEB_UP: begin
        if (!sync) begin
          state_d = S_PRS;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = S_REL;
          deb_d     = '0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = S_REL;
        deb_d   = '0;
      end
    endcase
    // Output level follows the next state so it flips on the same edge as the pulses.
    psw_out_d = !((state_d == S_PRS) || (state_d == S_DEB_UP));
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_REL;
      deb_q   <= '0;
      PSW_OUT <= 1'b1;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      PSW_OUT <= psw_out_d;
      PRESS   <= press_d;
      RELEASE <= release_d;
    end
  end

`ifdef PSW_LONG_EN
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - 1'b1;

  logic [CNT_W-1:0] hold_q;
  logic             held;

  // Bounces through S_DEB_UP keep counting, so a chattering release does not restart the hold.
  assign held = (state_q == S_PRS) || (state_q == S_DEB_UP);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      hold_q <= '0;
      LONG   <= 1'b0;
    end else begin
      LONG <= held && (hold_q == LONG_LAST);
      if (state_q == S_REL) begin
        hold_q <= '0;
      end else if (held && (hold_q != LONG_CYCLES)) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end
`else
  assign LONG = 1'b0;
`endif

endmodule

// File: tb/tb_psw_debounce.sv
// Directed, scoreboard-based bench for psw_debounce with DEB_CYCLES=4, LONG_CYCLES=10.
// Expected LONG activity depends on whether PSW_LONG_EN is defined for the build.
module tb_psw_debounce;
  import psw_debounce_pkg::*;

`ifdef PSW_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct packed {
    logic psw_out;
    logic press;
    logic rel;
    logic lng;
  } exp_t;

  logic CK, RST, PSW;
  logic PSW_OUT, PRESS, RELEASE, LONG;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  psw_debounce #(
    .DEB_CYCLES  (25'd4),
    .LONG_CYCLES (25'd10)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .PSW     (PSW),
    .PSW_OUT (PSW_OUT),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .LONG    (LONG)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input int k, input logic obs, input logic expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, k, obs, expv);
    end
  endtask

  // Pop one expected record and compare all outputs against it.
  task automatic check_cycle(input string tag, input int k);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s cyc=%0d observed=empty_queue expected=entry", tag, k);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".psw_out"}, k, PSW_OUT, e.psw_out);
      chk({tag, ".press"},   k, PRESS,   e.press);
      chk({tag, ".release"}, k, RELEASE, e.rel);
      chk({tag, ".long"},    k, LONG,    e.lng);
    end
  endtask

  function automatic logic [63:0] lows(input int a, input int b);
    logic [63:0] v;
    v = '1;
    for (int i = a; i < b; i++) v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Cycle k: PSW=pat[k] is sampled on edge k, outputs are checked just after edge k.
  // Scenario is expected to start from the released, idle condition.
  task automatic run_pat(input string tag, input logic [63:0] pat, input int n,
                         input logic [63:0] press_v, input logic [63:0] rel_v,
                         input logic [63:0] long_v, input int rst_at);
    logic cur;
    exp_t e;
    cur = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) cur = 1'b1;
      if (press_v[k])  cur = 1'b0;
      if (rel_v[k])    cur = 1'b1;
      e.psw_out = cur;
      e.press   = press_v[k];
      e.rel     = rel_v[k];
      e.lng     = LONG_EN && long_v[k];
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge CK);
      PSW = pat[k];
      RST = (k == rst_at);
      @(posedge CK);
      #1;
      check_cycle(tag, k);
    end
  endtask

  initial begin
    exp_t e;
    RST = 1'b1;
    PSW = 1'b1;

    // Reset held for three cycles while PSW toggles.
    e = '{psw_out: 1'b1, press: 1'b0, rel: 1'b0, lng: 1'b0};
    for (int k = 0; k < 3; k++) exp_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge CK);
      PSW = ~PSW;
      RST = 1'b1;
      @(posedge CK);
      #1;
      check_cycle("reset", k);
    end

    run_pat("idle", '1, 4, '0, '0, '0, -1);

    run_pat("bounce3", lows(0, 3), 12, '0, '0, '0, -1);
    total++;
    assert (dut.state_q === S_REL)
    else begin
      bad++;
      $error("FAIL bounce3.state observed=%0d expected=%0d", dut.state_q, S_REL);
    end

    run_pat("bounce4", lows(0, 4), 12, '0, '0, '0, -1);
    run_pat("press5",  lows(0, 5), 14, onehot(6), onehot(11), '0, -1);
    run_pat("short",   lows(0, 8), 18, onehot(6), onehot(14), '0, -1);
    run_pat("hold9",   lows(0, 9), 18, onehot(6), onehot(15), '0, -1);
    run_pat("hold10",  lows(0, 10), 20, onehot(6), onehot(16), onehot(16), -1);
    run_pat("long",    lows(0, 30), 40, onehot(6), onehot(36), onehot(16), -1);
    run_pat("upglitch", lows(0, 8) & lows(10, 30), 40,
            onehot(6), onehot(36), onehot(16), -1);
    run_pat("rst_dn",  lows(0, 14), 26, onehot(12), onehot(20), '0, 5);
    run_pat("rst_prs", lows(0, 19), 30, onehot(6) | onehot(16), onehot(25), '0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
